hydra_tx_arbiter: RTL



---
 rtl/hydra_pkg.sv | 32 +++
 rtl/rr_select4.sv | 37 +++
 rtl/hydra_tx_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/hydra_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hydra_pkg
// Description : Shared types and constants for the Hydra upstream transmit
//               arbiter: FSM state encoding, the FIFO source code used in
//               grant_src, the packet type and a one-hot decode helper.
// Revision    : 1.0  initial release
// ============================================================================
package hydra_pkg;

    // Default packet width including parity; data buses are one bit narrower.
    localparam int PKT_WIDTH = 64;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH      = 3'd1,
        LOAD       = 3'd2,
        WAIT_START = 3'd3,
        WAIT_DONE  = 3'd4
    } arb_state_t;

    // grant_src code for the local event FIFO; codes 0-3 are the relay ports.
    localparam logic [2:0] SRC_FIFO = 3'd4;

    typedef logic [PKT_WIDTH-2:0] packet_t;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage : hydra_pkg
`default_nettype wire

// File: rtl/rr_select4.sv
`default_nettype none
// ============================================================================
// Module      : rr_select4
// Description : Combinational 4-way round-robin picker. Searches req starting
//               at index ptr and wrapping modulo 4.
// Ports       : req[3:0]     request vector
//               ptr[1:0]     highest-priority index for this decision
//               gnt_idx[1:0] index of the winning request (ptr when none)
//               any          at least one request is present
// Revision    : 1.0  initial release
// ============================================================================
module rr_select4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] gnt_idx,
    output logic       any
);

    logic [1:0] idx;

    // Walk offsets from farthest to nearest so the request closest to ptr
    // is the last one written and therefore wins.
    always_comb begin
        gnt_idx = ptr;
        any     = 1'b0;
        idx     = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                gnt_idx = idx;
                any     = 1'b1;
            end
        end
    end

endmodule : rr_select4
`default_nettype wire

// File: rtl/hydra_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hydra_tx_arbiter
// Description : Schedules the shared upstream transmit path. Arbitrates the
//               local event FIFO against four RX relay buffers, then runs each
//               grant through fetch, load of every enabled TX UART, wait for
//               the loaded UARTs to start and finish, and release.
// Ports       : clk, reset_n_clk (async, active low)
//               enable_piso_upstream[3:0]  TX ports carrying upstream traffic
//               fifo_empty, fifo_data, read_fifo_n   local event FIFO
//               relay_valid, relay_data, relay_ack   RX relay buffers
//               tx_busy, ld_tx_data_uart, tx_data    UART TX interface
//               grant_src, arb_busy                  status
//               grant_cnt_fifo, grant_cnt_relay, timeout_cnt  statistics
// Options     : `define HYDRA_ARB_STATS_EN builds the saturating statistics
//               counters; otherwise the three counter ports read 0.
// Revision    : 1.0  initial release
// ============================================================================
module hydra_tx_arbiter
    import hydra_pkg::*;
#(
    parameter int WIDTH         = PKT_WIDTH,
    parameter int RELAY_BURST   = 4,
    parameter int START_TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   reset_n_clk,
    input  logic [3:0]             enable_piso_upstream,
    input  logic                   fifo_empty,
    input  logic [WIDTH-2:0]       fifo_data,
    output logic                   read_fifo_n,
    input  logic [3:0]             relay_valid,
    input  logic [4*(WIDTH-1)-1:0] relay_data,
    output logic [3:0]             relay_ack,
    input  logic [3:0]             tx_busy,
    output logic [3:0]             ld_tx_data_uart,
    output logic [WIDTH-2:0]       tx_data,
    output logic [2:0]             grant_src,
    output logic                   arb_busy,
    output logic [15:0]            grant_cnt_fifo,
    output logic [15:0]            grant_cnt_relay,
    output logic [15:0]            timeout_cnt
);

    localparam int              BW         = $clog2(RELAY_BURST + 1);
    localparam int              TW         = $clog2(START_TIMEOUT + 1);
    localparam logic [BW-1:0]   BURST_MAX  = BW'(RELAY_BURST);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(START_TIMEOUT - 1);

    arb_state_t       state, state_nx;
    logic [1:0]       rr_ptr;
    logic [BW-1:0]    burst_cnt;
    logic [3:0]       mask;
    logic [TW-1:0]    timer;

    logic [WIDTH-2:0] relay_pkt [4];
    logic [1:0]       rr_idx;
    logic             relay_any;
    logic             can_start;
    logic             fifo_wins;
    logic             busy_hit;
    logic             timer_done;
    logic             relay_grant;

    for (genvar p = 0; p < 4; p++) begin : g_unpack
        assign relay_pkt[p] = relay_data[p*(WIDTH-1) +: WIDTH-1];
    end

    rr_select4 u_rr (
        .req     (relay_valid),
        .ptr     (rr_ptr),
        .gnt_idx (rr_idx),
        .any     (relay_any)
    );

    assign can_start   = (|enable_piso_upstream) && ((tx_busy & enable_piso_upstream) == 4'd0)
                         && (relay_any || !fifo_empty);
    // Relays normally win; the FIFO is forced in once a full relay burst has
    // gone out while it was waiting.
    assign fifo_wins   = !fifo_empty && (!relay_any || burst_cnt == BURST_MAX);
    assign busy_hit    = |(tx_busy & mask);
    assign timer_done  = (timer == TIMER_LAST);
    assign relay_grant = (grant_src != SRC_FIFO);
    assign arb_busy    = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n_clk) begin
        if (!reset_n_clk) state <= IDLE;
        else              state <= state_nx;
    end

    always_comb begin
        state_nx        = state;
        read_fifo_n     = 1'b1;
        relay_ack       = 4'd0;
        ld_tx_data_uart = 4'd0;
        case (state)
            IDLE: begin
                if (can_start) begin
                    state_nx = FETCH;
                    if (fifo_wins) read_fifo_n = 1'b0;
                    else           relay_ack   = onehot4(rr_idx);
                end
            end
            FETCH:      state_nx = LOAD;
            LOAD: begin
                ld_tx_data_uart = mask;
                state_nx        = WAIT_START;
            end
            WAIT_START: begin
                if (busy_hit)        state_nx = WAIT_DONE;
                else if (timer_done) state_nx = IDLE;
            end
            WAIT_DONE:  if (!busy_hit) state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
        // The strobes are decoded from state, which resets asynchronously;
        // hold them inactive for the whole time reset is asserted.
        if (!reset_n_clk) begin
            read_fifo_n     = 1'b1;
            relay_ack       = 4'd0;
            ld_tx_data_uart = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n_clk) begin
        if (!reset_n_clk) begin
            mask      <= 4'd0;
            grant_src <= SRC_FIFO;
            rr_ptr    <= 2'd0;
            burst_cnt <= '0;
            timer     <= '0;
            tx_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (can_start) begin
                        mask      <= enable_piso_upstream;
                        grant_src <= fifo_wins ? SRC_FIFO : {1'b0, rr_idx};
                    end
                end
                FETCH: begin
                    if (relay_grant) begin
                        tx_data <= relay_pkt[grant_src[1:0]];
                        rr_ptr  <= grant_src[1:0] + 2'd1;
                        // The burst only counts while the FIFO is being held off.
                        if (fifo_empty)                   burst_cnt <= '0;
                        else if (burst_cnt != BURST_MAX)  burst_cnt <= burst_cnt + 1'b1;
                    end else begin
                        tx_data   <= fifo_data;
                        burst_cnt <= '0;
                    end
                end
                LOAD:       timer <= '0;
                WAIT_START: timer <= timer + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef HYDRA_ARB_STATS_EN
    logic [15:0] cnt_fifo, cnt_relay, cnt_to;

    always_ff @(posedge clk or negedge reset_n_clk) begin
        if (!reset_n_clk) begin
            cnt_fifo  <= 16'd0;
            cnt_relay <= 16'd0;
            cnt_to    <= 16'd0;
        end else begin
            if (state == FETCH && !relay_grant && cnt_fifo != 16'hFFFF)
                cnt_fifo <= cnt_fifo + 16'd1;
            if (state == FETCH && relay_grant && cnt_relay != 16'hFFFF)
                cnt_relay <= cnt_relay + 16'd1;
            if (state == WAIT_START && !busy_hit && timer_done && cnt_to != 16'hFFFF)
                cnt_to <= cnt_to + 16'd1;
        end
    end

    assign grant_cnt_fifo  = cnt_fifo;
    assign grant_cnt_relay = cnt_relay;
    assign timeout_cnt     = cnt_to;
`else
    assign grant_cnt_fifo  = 16'd0;
    assign grant_cnt_relay = 16'd0;
    assign timeout_cnt     = 16'd0;
`endif

endmodule : hydra_tx_arbiter
`default_nettype wire
